cla5_mp_add_seq: RTL and testbench
==================================

# cla5_mp_add_seq

Multi-precision add sequencer that drives one registered 5-bit carry-lookahead adder slice to add two WORDS×5-bit operands. Carry is chained between slices through the adder's registered carry-out. Upstream handshakes a request; downstream handshakes a result. The block owns the adder's operand and carry-in pins and sits between the requesting datapath and the shared 5-bit adder.

## Interface
- WORDS, default 4: number of 5-bit slices; operand width W = 5×WORDS; legal range 1–16.
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_a  in  W  operand A, little-endian slices; slice j is bits [5j+4:5j].
- req_b  in  W  operand B.
- req_cin  in  1  carry into slice 0.
- res_valid  out  1  result present.
- res_ready  in  1  downstream accepts the result.
- res_sum  out  W  sum.
- res_cout  out  1  carry out of slice WORDS-1.
- add_a  out  5  adder operand A.
- add_b  out  5  adder operand B.
- add_cin  out  1  adder carry-in.
- add_sum  in  5  adder registered sum.
- add_cout  in  1  adder registered carry-out.

## Operation
- Adder contract: add_a/add_b are sampled at the end of cycle t. add_cin is used combinationally during cycle t+1. add_sum/add_cout are registered at the end of t+1 and are valid during t+2. One new slice can be issued per cycle.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch req_a, req_b and req_cin, clear slice counter k, go to ISSUE.
- ISSUE: drive add_a/add_b with latched slice k, k increments each cycle. After slice WORDS-1, go to DRAIN.
- Carry: add_cin = latched req_cin in the cycle after slice 0 issues. It equals add_cout in the cycle after each later slice issues. Otherwise 0.
- Capture: add_sum for slice j is written into res_sum[5j+4:5j] in its valid cycle. add_cout is written into res_cout in the valid cycle of slice WORDS-1.
- DRAIN: wait for the last slice's capture, then go to DONE.
- DONE: res_valid=1. res_sum and res_cout are held stable until res_ready. On handshake, go to IDLE.
- Idle adder pins: add_a=0, add_b=0, add_cin=0 whenever no slice is issuing or in its carry cycle.
- No overlap: req_ready=0 in ISSUE, DRAIN and DONE. A request cannot be accepted in the same cycle as the result handshake.
- Arithmetic: {res_cout,res_sum} = req_a + req_b + req_cin, exact (W+1)-bit result, no truncation.

## Timing
- Reset (rst_n=0 at a rising edge): next cycle FSM=IDLE, req_ready=1, res_valid=0, res_sum=0, res_cout=0, add_a=0, add_b=0, add_cin=0, k=0. req_ready is 0 while rst_n is low.
- Request accepted at the end of cycle 0.
- Slice j issues in cycle j+1. Its carry-in is applied in cycle j+2. Its sum is captured at the end of cycle j+3.
- res_valid is first high in cycle WORDS+3 (cycle 7 for WORDS=4).
- After a result handshake at the end of cycle n: IDLE in cycle n+1, with req_ready=1. The next accept is possible at the end of n+1.
- Backpressure: with res_ready=0, res_valid stays 1 and res_sum/res_cout stay unchanged indefinitely.
- Reset mid-operation (any state): the transaction is aborted and the partial result discarded. res_valid is never raised for it, and adder pins go to 0.
- WORDS=1: ISSUE lasts one cycle, and res_valid is first high in cycle 4.
- req_a, req_b and req_cin are ignored outside the accepting cycle. Changing them mid-transaction has no effect.

## Test plan
- WORDS=4, A=0xFFFFF, B=0x00001, cin=0, res_ready=1 -> res_sum=0x00000, res_cout=1; res_valid in cycle 7; carry observed on add_cin in cycles 3, 4, 5.
- A=0x12345, B=0x0ABCD, cin=1 -> res_sum=0x1CF13, res_cout=0.
- A=0xFFFFF, B=0xFFFFF, cin=1, hold res_ready=0 for 10 cycles -> res_sum=0xFFFFF, res_cout=1 held stable; req_ready=0 throughout; accept after res_ready=1.
- Two back-to-back requests with req_valid held high -> second accepted exactly one cycle after the first result handshake; both results correct; add_a/add_b=0 between transactions.
- Assert rst_n=0 in cycle 3 of a transaction -> next cycle all outputs at reset values; no res_valid; a following request 0x00003+0x00004 yields 0x00007, cout 0.
- WORDS=1, A=0x1F, B=0x01, cin=1 -> res_sum=0x01, res_cout=1, res_valid in cycle 4.

Source files
------------

// File: rtl/cla5_mp_add_seq.sv
// cla5_mp_add_seq
//
// Adds two WORDS x 5-bit operands. It does this by issuing one slice per cycle to a shared,
// registered 5-bit carry-lookahead adder. The carry between slices is chained through the
// adder's registered carry-out. The request is latched on acceptance. The result is held in
// DONE until downstream takes it.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   req_valid  request present              req_ready  block can accept a request
//   req_a      operand A (slice j = [5j+4:5j])
//   req_b      operand B
//   req_cin    carry into slice 0
//   res_valid  result present               res_ready  downstream accepts the result
//   res_sum    W-bit sum                    res_cout   carry out of the top slice
//   add_a      adder operand A (5 bits)     add_b      adder operand B (5 bits)
//   add_cin    adder carry-in
//   add_sum    adder registered sum         add_cout   adder registered carry-out
//
// Adder pipeline seen from here:
//   - A slice is issued (add_a/add_b) in cycle t.
//   - Its carry-in is driven in cycle t+1.
//   - Its sum/carry are readable in cycle t+2.
module cla5_mp_add_seq #(
   parameter int unsigned WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [5*WORDS-1:0]   req_a,
   input  logic [5*WORDS-1:0]   req_b,
   input  logic                 req_cin,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [5*WORDS-1:0]   res_sum,
   output logic                 res_cout,
   output logic [4:0]           add_a,
   output logic [4:0]           add_b,
   output logic                 add_cin,
   input  logic [4:0]           add_sum,
   input  logic                 add_cout
);

   localparam int unsigned W  = 5 * WORDS;
   localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    a_q, b_q;
   logic [W-1:0]    sum_q, sum_d;
   logic            cin_q;
   logic            cout_q, cout_d;
   logic [KW-1:0]   k_q;
   // Slice tracking one and two cycles behind issue: carry cycle and capture cycle.
   logic            iss_v_q, cap_v_q;
   logic [KW-1:0]   iss_idx_q, cap_idx_q;

   logic            accept;
   logic            issuing;
   logic            last_k;
   logic            last_cap;

   assign accept   = req_valid && req_ready;
   assign issuing  = (state_q == StIssue);
   assign last_k   = (k_q == KW'(WORDS - 1));
   assign last_cap = cap_v_q && (cap_idx_q == KW'(WORDS - 1));

   // ---------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (accept)    state_d = StIssue;
         StIssue: if (last_k)    state_d = StDrain;
         StDrain: if (last_cap)  state_d = StDone;
         StDone:  if (res_ready) state_d = StIdle;
         default:                state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------------------
   always_comb begin
      // Gate with rst_n so nothing is accepted while reset is held.
      req_ready = rst_n && (state_q == StIdle);
      res_valid = (state_q == StDone);
      add_a     = 5'd0;
      add_b     = 5'd0;
      add_cin   = 1'b0;
      if (issuing) begin
         for (int j = 0; j < int'(WORDS); j++) begin
            if (k_q == KW'(j)) begin
               add_a = a_q[5*j +: 5];
               add_b = b_q[5*j +: 5];
            end
         end
      end
      // Carry cycle of the slice issued last cycle. For slice j > 0, add_cout currently
      // holds the carry out of slice j-1.
      if (iss_v_q) begin
         add_cin = (iss_idx_q == '0) ? cin_q : add_cout;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Result capture
   // ---------------------------------------------------------------------------------------
   always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
      if (cap_v_q) begin
         for (int j = 0; j < int'(WORDS); j++) begin
            if (cap_idx_q == KW'(j)) begin
               sum_d[5*j +: 5] = add_sum;
            end
         end
         if (last_cap) begin
            cout_d = add_cout;
         end
      end
   end

   // ---------------------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         k_q       <= '0;
         iss_v_q   <= 1'b0;
         iss_idx_q <= '0;
         cap_v_q   <= 1'b0;
         cap_idx_q <= '0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         if (accept) begin
            a_q   <= req_a;
            b_q   <= req_b;
            cin_q <= req_cin;
            k_q   <= '0;
         end else if (issuing) begin
            k_q <= last_k ? '0 : k_q + KW'(1);
         end
         iss_v_q   <= issuing;
         iss_idx_q <= k_q;
         cap_v_q   <= iss_v_q;
         cap_idx_q <= iss_idx_q;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
      end
   end

   assign res_sum  = sum_q;
   assign res_cout = cout_q;

endmodule

// File: tb/tb_cla5_mp_add_seq.sv
// Testbench for cla5_mp_add_seq.
// Drives a WORDS=4 instance and a WORDS=1 instance, each paired with its own behavioural
// registered 5-bit adder. Expected results are pushed to per-instance queues when a request
// is accepted. A monitor pops and compares on each result handshake.
module tb_cla5_mp_add_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // ---------------- WORDS = 4 instance ----------------
   logic        v4, rdy4, cin4;
   logic [19:0] a4, b4;
   logic        d4_req_ready, d4_res_valid, d4_res_cout, d4_add_cin, d4_add_cout;
   logic [19:0] d4_res_sum;
   logic [4:0]  d4_add_a, d4_add_b, d4_add_sum;

   cla5_mp_add_seq #(.WORDS(4)) u_d4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (v4),
      .req_ready (d4_req_ready),
      .req_a     (a4),
      .req_b     (b4),
      .req_cin   (cin4),
      .res_valid (d4_res_valid),
      .res_ready (rdy4),
      .res_sum   (d4_res_sum),
      .res_cout  (d4_res_cout),
      .add_a     (d4_add_a),
      .add_b     (d4_add_b),
      .add_cin   (d4_add_cin),
      .add_sum   (d4_add_sum),
      .add_cout  (d4_add_cout)
   );

   // ---------------- WORDS = 1 instance ----------------
   logic        v1, rdy1, cin1;
   logic [4:0]  a1, b1;
   logic        d1_req_ready, d1_res_valid, d1_res_cout, d1_add_cin, d1_add_cout;
   logic [4:0]  d1_res_sum;
   logic [4:0]  d1_add_a, d1_add_b, d1_add_sum;

   cla5_mp_add_seq #(.WORDS(1)) u_d1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (v1),
      .req_ready (d1_req_ready),
      .req_a     (a1),
      .req_b     (b1),
      .req_cin   (cin1),
      .res_valid (d1_res_valid),
      .res_ready (rdy1),
      .res_sum   (d1_res_sum),
      .res_cout  (d1_res_cout),
      .add_a     (d1_add_a),
      .add_b     (d1_add_b),
      .add_cin   (d1_add_cin),
      .add_sum   (d1_add_sum),
      .add_cout  (d1_add_cout)
   );

   // Adder models: operands registered at end of t, carry-in used in t+1, result registered.
   logic [4:0] op4_a, op4_b, op1_a, op1_b;
   always @(posedge clk) begin
      if (!rst_n) begin
         op4_a <= 5'd0; op4_b <= 5'd0; {d4_add_cout, d4_add_sum} <= 6'd0;
         op1_a <= 5'd0; op1_b <= 5'd0; {d1_add_cout, d1_add_sum} <= 6'd0;
      end else begin
         op4_a <= d4_add_a;
         op4_b <= d4_add_b;
         {d4_add_cout, d4_add_sum} <= {1'b0, op4_a} + {1'b0, op4_b} + {5'd0, d4_add_cin};
         op1_a <= d1_add_a;
         op1_b <= d1_add_b;
         {d1_add_cout, d1_add_sum} <= {1'b0, op1_a} + {1'b0, op1_b} + {5'd0, d1_add_cin};
      end
   end

   logic [20:0] exp4[$];
   logic [5:0]  exp1[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Monitor: compare on every result handshake.
   always @(negedge clk) begin
      if (rst_n && d4_res_valid && rdy4) begin
         if (exp4.size() == 0) check("sb4_unexpected_result", 32'd1, 32'd0);
         else check("sb4_result", {11'd0, d4_res_cout, d4_res_sum}, {11'd0, exp4.pop_front()});
      end
      if (rst_n && d1_res_valid && rdy1) begin
         if (exp1.size() == 0) check("sb1_unexpected_result", 32'd1, 32'd0);
         else check("sb1_result", {26'd0, d1_res_cout, d1_res_sum}, {26'd0, exp1.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Wait (bounded) for d4 res_valid, then let the handshake edge pass.
   task automatic wait_res4(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (d4_res_valid) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check(name, {31'd0, seen}, 32'd1);
      @(posedge clk); #1;
   endtask

   // Issue one request on d4 with res_ready held high; expected value is hand-computed.
   task automatic run4(input logic [19:0] a, input logic [19:0] b, input logic cin,
                       input logic [19:0] es, input logic ec, input string name);
      bit ok = 1'b0;
      a4 = a; b4 = b; cin4 = cin; v4 = 1'b1; rdy4 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         ok = d4_req_ready;
         if (ok) exp4.push_back({ec, es});
         @(posedge clk); #1;
         if (ok) break;
      end
      check({name, "_accept"}, {31'd0, ok}, 32'd1);
      v4 = 1'b0; a4 = 20'h0; b4 = 20'h0; cin4 = 1'b0;
      wait_res4({name, "_valid"});
   endtask

   initial begin
      rst_n = 1'b0;
      v4 = 1'b0; rdy4 = 1'b1; a4 = 20'h0; b4 = 20'h0; cin4 = 1'b0;
      v1 = 1'b0; rdy1 = 1'b1; a1 = 5'h0; b1 = 5'h0; cin1 = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_req_ready_low", {31'd0, d4_req_ready}, 32'd0);
      check("rst_res_valid", {31'd0, d4_res_valid}, 32'd0);
      check("rst_res_sum", {11'd0, d4_res_cout, d4_res_sum}, 32'd0);
      check("rst_add_pins", {21'd0, d4_add_a, d4_add_b, d4_add_cin}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Test 1: FFFFF + 00001, carry ripples through every slice.
      a4 = 20'hFFFFF; b4 = 20'h00001; cin4 = 1'b0; v4 = 1'b1; rdy4 = 1'b1;
      @(negedge clk);
      check("t1_ready_c0", {31'd0, d4_req_ready}, 32'd1);
      exp4.push_back({1'b1, 20'h00000});
      @(posedge clk); #1;
      // Change inputs mid-transaction; they must be ignored.
      v4 = 1'b0; a4 = 20'h0; b4 = 20'h0; cin4 = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) check("t1_add_ab_c1", {22'd0, d4_add_a, d4_add_b}, {22'd0, 5'h1F, 5'h01});
         if (c == 2) begin
            check("t1_add_ab_c2", {22'd0, d4_add_a, d4_add_b}, {22'd0, 5'h1F, 5'h00});
            check("t1_add_cin_c2", {31'd0, d4_add_cin}, 32'd0);
         end
         if (c >= 3 && c <= 5) check("t1_add_cin_carry", {31'd0, d4_add_cin}, 32'd1);
         if (c == 6) begin
            check("t1_add_cin_c6", {31'd0, d4_add_cin}, 32'd0);
            check("t1_valid_c6", {31'd0, d4_res_valid}, 32'd0);
            check("t1_add_ab_c6", {22'd0, d4_add_a, d4_add_b}, 32'd0);
         end
         if (c == 7) check("t1_valid_c7", {31'd0, d4_res_valid}, 32'd1);
         if (c <= 7) check("t1_ready_busy", {31'd0, d4_req_ready}, 32'd0);
         if (c == 8) begin
            check("t1_valid_c8", {31'd0, d4_res_valid}, 32'd0);
            check("t1_ready_c8", {31'd0, d4_req_ready}, 32'd1);
         end
         @(posedge clk); #1;
      end
      cin4 = 1'b0;

      // Test 2: 12345 + 0ABCD + 1 = 1CF13.
      run4(20'h12345, 20'h0ABCD, 1'b1, 20'h1CF13, 1'b0, "t2");

      // Test 3/4: backpressure, then a held request accepted right after the handshake.
      rdy4 = 1'b0;
      a4 = 20'hFFFFF; b4 = 20'hFFFFF; cin4 = 1'b1; v4 = 1'b1;
      @(negedge clk);
      check("t3_ready_c0", {31'd0, d4_req_ready}, 32'd1);
      exp4.push_back({1'b1, 20'hFFFFF});
      @(posedge clk); #1;
      a4 = 20'h00010; b4 = 20'h0000F; cin4 = 1'b0;
      begin
         bit seen = 1'b0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (d4_res_valid) begin
               seen = 1'b1;
               break;
            end
            check("t3_ready_busy", {31'd0, d4_req_ready}, 32'd0);
            @(posedge clk); #1;
         end
         check("t3_valid_seen", {31'd0, seen}, 32'd1);
      end
      for (int i = 0; i < 10; i++) begin
         if (i > 0) @(negedge clk);
         check("t3_hold", {9'd0, d4_res_valid, d4_req_ready, d4_res_cout, d4_res_sum},
               {9'd0, 1'b1, 1'b0, 1'b1, 20'hFFFFF});
         @(posedge clk); #1;
      end
      rdy4 = 1'b1;
      @(negedge clk);
      check("t3_no_overlap", {31'd0, d4_req_ready}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t4_ready_n1", {31'd0, d4_req_ready}, 32'd1);
      check("t4_valid_n1", {31'd0, d4_res_valid}, 32'd0);
      check("t4_add_idle", {22'd0, d4_add_a, d4_add_b}, 32'd0);
      exp4.push_back({1'b0, 20'h0001F});
      @(posedge clk); #1;
      v4 = 1'b0;
      @(negedge clk);
      check("t4_accepted", {31'd0, d4_req_ready}, 32'd0);
      @(posedge clk); #1;
      wait_res4("t4_valid");

      // Test 5: reset in cycle 3 aborts the transaction.
      a4 = 20'h54321; b4 = 20'h11111; cin4 = 1'b0; v4 = 1'b1;
      @(negedge clk);
      check("t5_ready_c0", {31'd0, d4_req_ready}, 32'd1);
      @(posedge clk); #1;
      v4 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("t5_ready_in_rst", {31'd0, d4_req_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_post_rst_out", {9'd0, d4_res_valid, d4_res_cout, d4_res_sum, 1'b0},
            32'd0);
      check("t5_post_rst_pins", {21'd0, d4_add_a, d4_add_b, d4_add_cin}, 32'd0);
      check("t5_post_rst_ready", {31'd0, d4_req_ready}, 32'd1);
      begin
         bit any_valid = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            any_valid |= d4_res_valid;
         end
         check("t5_no_valid", {31'd0, any_valid}, 32'd0);
      end
      @(posedge clk); #1;
      run4(20'h00003, 20'h00004, 1'b0, 20'h00007, 1'b0, "t5_next");

      // Test 6: WORDS=1, 1F + 01 + 1 = 0x21.
      a1 = 5'h1F; b1 = 5'h01; cin1 = 1'b1; v1 = 1'b1; rdy1 = 1'b1;
      @(negedge clk);
      check("t6_ready_c0", {31'd0, d1_req_ready}, 32'd1);
      exp1.push_back({1'b1, 5'h01});
      @(posedge clk); #1;
      v1 = 1'b0; a1 = 5'h0; b1 = 5'h0; cin1 = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) check("t6_add_ab_c1", {22'd0, d1_add_a, d1_add_b}, {22'd0, 5'h1F, 5'h01});
         if (c == 2) check("t6_add_cin_c2", {31'd0, d1_add_cin}, 32'd1);
         check("t6_valid_timing", {31'd0, d1_res_valid}, (c == 4) ? 32'd1 : 32'd0);
         @(posedge clk); #1;
      end

      repeat (3) @(posedge clk);
      #1;
      check("sb4_drained", exp4.size(), 32'd0);
      check("sb1_drained", exp1.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
